// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode/funct3 constants and the decoded issue-entry layout.
// Entries are stored already decoded so the issue stage never re-decodes.
package alu_pkg;

    localparam int ENTRY_XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_EQ  = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_NE  = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_LT  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_GE  = 4'b1011;
    localparam logic [3:0] ALU_OR  = 4'b1100;
    localparam logic [3:0] ALU_LUI = 4'b1110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] a;
        logic [ENTRY_XLEN-1:0] b;
        logic [3:0]            op;
        logic                  us;
        logic [4:0]            rd;
        logic                  we;
        logic                  branch;
        logic [ENTRY_XLEN-1:0] target;
        logic [ENTRY_XLEN-1:0] store_data;
        logic                  illegal;
    } issue_entry_t;

    function automatic logic [ENTRY_XLEN-1:0] sext12(input logic [11:0] v);
        return {{(ENTRY_XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv32i_alu_decode.sv
// Purely combinational RV32I instruction -> ALU issue entry decode; zero latency, no handshake.
module rv32i_alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]           instr,
    input  logic [ENTRY_XLEN-1:0] pc,
    input  logic [ENTRY_XLEN-1:0] rs1_data,
    input  logic [ENTRY_XLEN-1:0] rs2_data,
    output issue_entry_t          entry
);

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic                  alt;
    logic [ENTRY_XLEN-1:0] i_imm;
    logic [ENTRY_XLEN-1:0] s_imm;
    logic [ENTRY_XLEN-1:0] b_imm;
    logic [ENTRY_XLEN-1:0] u_imm;
    logic [ENTRY_XLEN-1:0] shamt;
    logic                  we_raw;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign alt    = instr[30];
    assign i_imm  = sext12(instr[31:20]);
    assign s_imm  = sext12({instr[31:25], instr[11:7]});
    assign b_imm  = {{(ENTRY_XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm  = {instr[31:12], 12'b0};
    assign shamt  = {{(ENTRY_XLEN-5){1'b0}}, instr[24:20]};

    always_comb begin
        entry            = '0;
        we_raw           = 1'b0;
        entry.rd         = instr[11:7];
        entry.store_data = rs2_data;
        entry.a          = rs1_data;
        entry.b          = rs2_data;
        entry.op         = ALU_ADD;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                we_raw = 1'b1;
                if (opcode == OPC_OP_IMM) begin
                    entry.b = (f3 == F3_SLL || f3 == F3_SR) ? shamt : i_imm;
                end
                case (f3)
                    F3_ADD:  entry.op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  entry.op = ALU_SLL;
                    F3_SLT:  entry.op = ALU_SLT;
                    F3_SLTU: begin entry.op = ALU_SLT; entry.us = 1'b1; end
                    F3_XOR:  entry.op = ALU_XOR;
                    F3_SR:   entry.op = alt ? ALU_SRA : ALU_SRL;
                    F3_OR:   entry.op = ALU_OR;
                    default: entry.op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                entry.op = ALU_LUI;
                entry.b  = u_imm;
                we_raw   = 1'b1;
            end
            OPC_AUIPC: begin
                entry.a = pc;
                entry.b = u_imm;
                we_raw  = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                entry.a = pc;
                entry.b = ENTRY_XLEN'(4);
                we_raw  = 1'b1;
            end
            OPC_LOAD: begin
                entry.b = i_imm;
                we_raw  = 1'b1;
            end
            OPC_STORE: entry.b = s_imm;
            OPC_BRANCH: begin
                entry.target = pc + b_imm;
                entry.branch = 1'b1;
                case (f3)
                    F3_BEQ:  entry.op = ALU_EQ;
                    F3_BNE:  entry.op = ALU_NE;
                    F3_BLT:  entry.op = ALU_LT;
                    F3_BGE:  entry.op = ALU_GE;
                    F3_BLTU: begin entry.op = ALU_LT; entry.us = 1'b1; end
                    F3_BGEU: begin entry.op = ALU_GE; entry.us = 1'b1; end
                    default: begin
                        entry.branch  = 1'b0;
                        entry.illegal = 1'b1;
                        entry.target  = '0;
                    end
                endcase
            end
            default: entry.illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded, so never request them.
        entry.we = we_raw && (entry.rd != 5'd0);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes on accept into a 2-entry skid buffer; 1-cycle latency, 1 op/cycle.
// in_ready is registered (!skid valid); a held output diverts one extra entry into skid; flush drops all.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic            alu_us,
    output logic [4:0]      rd,
    output logic            reg_we,
    output logic            is_branch,
    output logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] store_data,
    output logic            illegal
);

    if (DEPTH != 2 || XLEN != ENTRY_XLEN) begin : g_bad_cfg
        $error("alu_issue_stage supports only DEPTH=2 and XLEN=%0d", ENTRY_XLEN);
    end

    issue_entry_t dec_entry;
    issue_entry_t main_d, main_q;
    issue_entry_t skid_d, skid_q;
    logic         main_vld_d, main_vld_q;
    logic         skid_vld_d, skid_vld_q;
    logic         in_rdy_d, in_rdy_q;
    logic         accept;
    logic         drain;

    rv32i_alu_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .entry    (dec_entry)
    );

    assign accept = in_valid && in_rdy_q;
    assign drain  = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            // Skid is older than anything arriving now, so it refills main first.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = dec_entry;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = dec_entry;
            skid_vld_d = 1'b1;
        end
        in_rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign in_ready   = in_rdy_q;
    assign out_valid  = main_vld_q;
    assign alu_a      = main_q.a;
    assign alu_b      = main_q.b;
    assign alu_op     = main_q.op;
    assign alu_us     = main_q.us;
    assign rd         = main_q.rd;
    assign reg_we     = main_q.we;
    assign is_branch  = main_q.branch;
    assign br_target  = main_q.target;
    assign store_data = main_q.store_data;
    assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid ordering, flush and async reset.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_us;
    logic [4:0]  rd;
    logic        reg_we;
    logic        is_branch;
    logic [31:0] br_target;
    logic [31:0] store_data;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_us     (alu_us),
        .rd         (rd),
        .reg_we     (reg_we),
        .is_branch  (is_branch),
        .br_target  (br_target),
        .store_data (store_data),
        .illegal    (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    // One instruction through an empty stage with out_ready high; result is on the outputs on return.
    task automatic issue_one(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
        out_ready = 1'b1;
        drive(i, p, r1, r2);
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        step(); step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if ({alu_a, alu_b, alu_op, rd, reg_we, illegal} !== '0) begin n_err++; $display("FAIL reset_outputs got a=%h b=%h op=%b rd=%0d we=%b ill=%b want 0", alu_a, alu_b, alu_op, rd, reg_we, illegal); end
        @(negedge clk); reset = 1'b0;
        step();
    endtask

    task automatic test_op_reg();
        issue_one(32'h002081B3, 32'h0, 32'd5, 32'd7);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_vec++; if (alu_op !== 4'b0000) begin n_err++; $display("FAIL add_op got %b want 0000", alu_op); end
        n_vec++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin n_err++; $display("FAIL add_ab got %0d,%0d want 5,7", alu_a, alu_b); end
        n_vec++; if (rd !== 5'd3 || reg_we !== 1'b1) begin n_err++; $display("FAIL add_rd_we got %0d,%b want 3,1", rd, reg_we); end
        issue_one(32'h402081B3, 32'h0, 32'd5, 32'd7);
        n_vec++; if (alu_op !== 4'b0001) begin n_err++; $display("FAIL sub_op got %b want 0001", alu_op); end
        issue_one(32'h00208033, 32'h0, 32'd5, 32'd7);
        n_vec++; if (reg_we !== 1'b0 || rd !== 5'd0) begin n_err++; $display("FAIL rd0_we got we=%b rd=%0d want 0,0", reg_we, rd); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_op_imm_lui();
        issue_one(32'h4040D193, 32'h0, 32'hF000_0000, 32'd9);
        n_vec++; if (alu_op !== 4'b0110 || alu_us !== 1'b0) begin n_err++; $display("FAIL srai_op got %b us=%b want 0110 us=0", alu_op, alu_us); end
        n_vec++; if (alu_b !== 32'd4 || alu_a !== 32'hF000_0000) begin n_err++; $display("FAIL srai_ab got %h,%h want f0000000,4", alu_a, alu_b); end
        // sltiu x1,x2,-1: sign-extended immediate, unsigned compare
        issue_one(32'hFFF13093, 32'h0, 32'd1, 32'd0);
        n_vec++; if (alu_op !== 4'b0011 || alu_us !== 1'b1 || alu_b !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sltiu got op=%b us=%b b=%h want 0011 1 ffffffff", alu_op, alu_us, alu_b); end
        issue_one(32'h123452B7, 32'h0, 32'd0, 32'd0);
        n_vec++; if (alu_op !== 4'b1110 || alu_b !== 32'h1234_5000) begin n_err++; $display("FAIL lui got op=%b b=%h want 1110 12345000", alu_op, alu_b); end
        n_vec++; if (rd !== 5'd5 || reg_we !== 1'b1) begin n_err++; $display("FAIL lui_rd got %0d we=%b want 5 1", rd, reg_we); end
        // sw x2,-4(x1): S-immediate, no writeback, rs2 passed through
        issue_one(32'hFE20AE23, 32'h0, 32'h100, 32'hCAFE);
        n_vec++; if (alu_b !== 32'hFFFF_FFFC || reg_we !== 1'b0 || store_data !== 32'hCAFE) begin n_err++; $display("FAIL sw got b=%h we=%b sd=%h want fffffffc 0 cafe", alu_b, reg_we, store_data); end
        // jal x1,0 at pc 0x40: link value pc+4 computed by ALU
        issue_one(32'h000000EF, 32'h40, 32'd0, 32'd0);
        n_vec++; if (alu_a !== 32'h40 || alu_b !== 32'd4 || alu_op !== 4'b0000 || reg_we !== 1'b1) begin n_err++; $display("FAIL jal got a=%h b=%h op=%b we=%b want 40 4 0000 1", alu_a, alu_b, alu_op, reg_we); end
    endtask

    task automatic test_branch();
        issue_one(32'h0020E463, 32'h100, 32'd1, 32'd2);
        n_vec++; if (alu_op !== 4'b1001 || alu_us !== 1'b1) begin n_err++; $display("FAIL bltu_op got %b us=%b want 1001 1", alu_op, alu_us); end
        n_vec++; if (is_branch !== 1'b1 || reg_we !== 1'b0) begin n_err++; $display("FAIL bltu_flags got br=%b we=%b want 1 0", is_branch, reg_we); end
        n_vec++; if (br_target !== 32'h108) begin n_err++; $display("FAIL bltu_target got %h want 00000108", br_target); end
        // beq x0,x0,+8 at top of address space: target wraps
        issue_one(32'h00000463, 32'hFFFF_FFFC, 32'd0, 32'd0);
        n_vec++; if (br_target !== 32'h4 || alu_op !== 4'b0101) begin n_err++; $display("FAIL beq_wrap got t=%h op=%b want 00000004 0101", br_target, alu_op); end
        // bne x1,x2,-4: negative B-immediate
        issue_one(32'hFE209EE3, 32'h200, 32'd1, 32'd2);
        n_vec++; if (br_target !== 32'h1FC || alu_op !== 4'b0111) begin n_err++; $display("FAIL bne_back got t=%h op=%b want 000001fc 0111", br_target, alu_op); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(32'h00100093, 32'h0, 32'd0, 32'd0);
        step();
        n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_i0 got v=%b rdy=%b want 1 1", out_valid, in_ready); end
        drive(32'h00200113, 32'h0, 32'd0, 32'd0);
        step();
        n_vec++; if (in_ready !== 1'b0 || rd !== 5'd1) begin n_err++; $display("FAIL b2b_full got rdy=%b rd=%0d want 0 1", in_ready, rd); end
        drive(32'h00300193, 32'h0, 32'd0, 32'd0);
        step();
        n_vec++; if (in_ready !== 1'b0 || rd !== 5'd1 || alu_b !== 32'd1) begin n_err++; $display("FAIL b2b_hold got rdy=%b rd=%0d b=%0d want 0 1 1", in_ready, rd, alu_b); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_valid !== 1'b1 || rd !== 5'd2 || alu_b !== 32'd2) begin n_err++; $display("FAIL b2b_i1 got v=%b rd=%0d b=%0d want 1 2 2", out_valid, rd, alu_b); end
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || rd !== 5'd3 || alu_b !== 32'd3) begin n_err++; $display("FAIL b2b_i2 got v=%b rd=%0d b=%0d want 1 3 3", out_valid, rd, alu_b); end
        step();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_empty got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_flush_reset();
        out_ready = 1'b0;
        drive(32'h00100093, 32'h0, 32'd0, 32'd0);
        step();
        drive(32'h00200113, 32'h0, 32'd0, 32'd0);
        step();
        drive(32'h00300193, 32'h0, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush got v=%b rdy=%b want 0 1", out_valid, in_ready); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got v=%b rd=%0d want 0", out_valid, rd); end
        out_ready = 1'b0;
        drive(32'h00500293, 32'h0, 32'd0, 32'd0);
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || rd !== 5'd5) begin n_err++; $display("FAIL pre_reset got v=%b rd=%0d want 1 5", out_valid, rd); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd !== 5'd0 || alu_b !== 32'd0) begin n_err++; $display("FAIL async_reset got v=%b rdy=%b rd=%0d b=%h want 0 1 0 0", out_valid, in_ready, rd, alu_b); end
        @(negedge clk); reset = 1'b0;
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset got v=%b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(32'h000000FF, 32'h0, 32'd1, 32'd2);
        step();
        drive(32'h0020A463, 32'h100, 32'd1, 32'd2);
        n_vec++; if (illegal !== 1'b1 || reg_we !== 1'b0 || is_branch !== 1'b0 || alu_op !== 4'b0000) begin n_err++; $display("FAIL ill_opc got ill=%b we=%b br=%b op=%b want 1 0 0 0000", illegal, reg_we, is_branch, alu_op); end
        step();
        drive(32'h002081B3, 32'h0, 32'd10, 32'd20);
        n_vec++; if (out_valid !== 1'b1 || illegal !== 1'b1 || is_branch !== 1'b0 || reg_we !== 1'b0) begin n_err++; $display("FAIL ill_br got v=%b ill=%b br=%b we=%b want 1 1 0 0", out_valid, illegal, is_branch, reg_we); end
        step();
        in_valid = 1'b0;
        n_vec++; if (illegal !== 1'b0 || reg_we !== 1'b1 || rd !== 5'd3 || alu_a !== 32'd10) begin n_err++; $display("FAIL ill_next got ill=%b we=%b rd=%0d a=%0d want 0 1 3 10", illegal, reg_we, rd, alu_a); end
        step();
    endtask

    initial begin
        test_reset();
        test_op_reg();
        test_op_imm_lui();
        test_branch();
        test_back_to_back();
        test_flush_reset();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
